// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: shared state type, default bound table and table accessor
// for the LED-bar flasher.
package bound_flasher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    localparam int MAX_STEP = 32;
    localparam int TBL_W    = MAX_STEP * 8;

    localparam logic [47:0] DEF_BOUNDS =
        {8'd0, 8'd6, 8'd0, 8'd11, 8'd5, 8'd16};

    function automatic logic [7:0] bound_at(
        input logic [TBL_W-1:0] tbl,
        input logic [4:0]       k
    );
        return tbl[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bound_flasher_seq_flick_sync.sv
// flick_sync: SYNC_STAGES-deep flop chain bringing the asynchronous
// flick request into the clk domain; all flops reset to 0.
module flick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flick,
    output logic flick_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], flick};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign flick_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bound_flasher_seq.sv
// bound_flasher_seq: thermometer LED-bar sequencer walking an UP/DOWN bound table.
// Define BOUND_FLASHER_KICKBACK_EN to let flick re-run the previous UP phase.
module bound_flasher_seq
    import bound_flasher_pkg::*;
#(
    parameter int                  N_LED       = 16,
    parameter int                  N_STEP      = 6,
    parameter logic [N_STEP*8-1:0] BOUNDS      = DEF_BOUNDS,
    parameter int                  KICK_LO     = 0,
    parameter int                  KICK_HI     = 5,
    parameter int                  TICK_DIV    = 1,
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flick,
    output logic [N_LED-1:0]                      led,
    output logic                                  busy,
    output logic [((N_STEP>1)?$clog2(N_STEP):1)-1:0] step_o,
    output logic                                  done
);

    localparam int CW = $clog2(N_LED + 1);
    localparam int SW = (N_STEP > 1) ? $clog2(N_STEP) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TBL_W-1:0] TBL = TBL_W'(BOUNDS);

`ifdef BOUND_FLASHER_KICKBACK_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif

    if (N_STEP < 2 || N_STEP % 2 != 0 || N_STEP > MAX_STEP) begin : g_bad_n
        $error("N_STEP must be even and within 2..%0d", MAX_STEP);
    end
    if (TICK_DIV < 1 || SYNC_STAGES < 2) begin : g_bad_cfg
        $error("TICK_DIV must be >=1 and SYNC_STAGES >=2");
    end
    for (genvar k = 0; k < N_STEP; k++) begin : g_chk
        if (int'(bound_at(TBL, 5'(k))) > N_LED) begin : g_range
            $error("bound of step %0d exceeds N_LED", k);
        end
        if (k > 0 && k % 2 == 0 &&
            bound_at(TBL, 5'(k)) <= bound_at(TBL, 5'(k - 1))) begin : g_up
            $error("UP bound of step %0d not above previous", k);
        end
        if (k % 2 == 1 &&
            bound_at(TBL, 5'(k)) >= bound_at(TBL, 5'(k - 1))) begin : g_dn
            $error("DOWN bound of step %0d not below previous", k);
        end
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   step_q, step_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;
    logic            flick_s;
    logic [CW-1:0]   bnd;
    logic            tick, last, at_bound, kick;

    flick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .flick  (flick),
        .flick_s(flick_s)
    );

    assign bnd      = CW'(bound_at(TBL, 5'(step_q)));
    assign tick     = presc_q == PW'(TICK_DIV - 1);
    assign last     = step_q == SW'(N_STEP - 1);
    assign at_bound = cnt_q == bnd;
    assign kick     = KICK_EN && state_q == DOWN && !last && flick_s &&
                      (cnt_q == CW'(KICK_LO) || cnt_q == CW'(KICK_HI));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                step_d  = '0;
                if (flick_s) begin
                    state_d = UP;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            UP, DOWN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (kick) begin
                        state_d = UP;
                        step_d  = step_q - SW'(1);
                        cnt_d   = cnt_q + CW'(1);
                    end else if (at_bound && last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        step_d  = '0;
                        done_d  = 1'b1;
                    end else if (at_bound) begin
                        // turn around on the same tick: no dwell at the bound
                        step_d = step_q + SW'(1);
                        if (state_q == UP) begin
                            state_d = DOWN;
                            cnt_d   = cnt_q - CW'(1);
                        end else begin
                            state_d = UP;
                            cnt_d   = cnt_q + CW'(1);
                        end
                    end else if (state_q == UP) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                step_d  = '0;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        led = '0;
        for (int i = 0; i < N_LED; i++) begin
            led[i] = int'(cnt_q) > i;
        end
    end

    assign busy   = state_q != IDLE;
    assign step_o = step_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bound_flasher_seq.sv
// tb_bound_flasher_seq: scoreboard bench for bound_flasher_seq with default
// parameters; expectations follow BOUND_FLASHER_KICKBACK_EN when defined.
module tb_bound_flasher_seq;

`ifdef BOUND_FLASHER_KICKBACK_EN
    localparam bit KICK = 1'b1;
`else
    localparam bit KICK = 1'b0;
`endif

    localparam int PH_FROM [6] = '{1, 15, 6, 10, 1, 5};
    localparam int PH_TO   [6] = '{16, 5, 11, 0, 6, 0};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flick = 1'b1;
    logic [15:0] led;
    logic        busy;
    logic [2:0]  step_o;
    logic        done;

    int n_tot = 0;
    int n_bad = 0;

    logic [20:0] exq[$];
    bit          fl[$];

    bound_flasher_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flick (flick),
        .led   (led),
        .busy  (busy),
        .step_o(step_o),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] pack(logic b, int st, int c, logic d);
        return {16'((32'd1 << c) - 32'd1), b, 3'(st), d};
    endfunction

    task automatic push(logic b, int st, int c, logic d);
        exq.push_back(pack(b, st, c, d));
        fl.push_back(1'b0);
    endtask

    // flick_s is high at the edge that consumes the last pushed state
    task automatic flick_on_last();
        fl[fl.size() - 2] = 1'b1;
    endtask

    task automatic ramp(int st, int a, int b);
        if (a <= b) begin
            for (int c = a; c <= b; c++) push(1'b1, st, c, 1'b0);
        end else begin
            for (int c = a; c >= b; c--) push(1'b1, st, c, 1'b0);
        end
    endtask

    task automatic phases(int a, int b);
        for (int k = a; k <= b; k++) ramp(k, PH_FROM[k], PH_TO[k]);
    endtask

    task automatic start();
        push(1'b0, 0, 0, 1'b0);
        push(1'b0, 0, 0, 1'b0);
        flick_on_last();
    endtask

    task automatic finish_seq();
        push(1'b0, 0, 0, 1'b1);
        push(1'b0, 0, 0, 1'b0);
    endtask

    task automatic run(string name);
        logic [20:0] e;
        int t;
        t = 0;
        while (exq.size() > 0) begin
            flick = fl.pop_front();
            @(posedge clk);
            #1;
            e = exq.pop_front();
            chk($sformatf("%s#%0d", name, t),
                {11'd0, led, busy, step_o, done}, {11'd0, e});
            t++;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with flick high
        repeat (3) @(posedge clk);
        #1;
        chk("rst", {11'd0, led, busy, step_o, done}, 32'd0);
        @(negedge clk);
        chk("rst_n", {11'd0, led, busy, step_o, done}, 32'd0);
        rst_n = 1'b1;
        push(1'b0, 0, 0, 1'b0);
        push(1'b0, 0, 0, 1'b0);
        fl[0] = 1'b1;
        fl[1] = 1'b1;
        phases(0, 5);
        finish_seq();
        run("t1");

        start();
        phases(0, 5);
        finish_seq();
        run("t2");

        start();
        phases(0, 1);
        flick_on_last();
        if (KICK) begin
            ramp(0, 6, 16);
            phases(1, 5);
        end else begin
            phases(2, 5);
        end
        finish_seq();
        run("t3");

        start();
        phases(0, 3);
        flick_on_last();
        if (KICK) begin
            ramp(2, 1, 11);
            phases(3, 5);
        end else begin
            phases(4, 5);
        end
        finish_seq();
        run("t4");

        start();
        phases(0, 4);
        for (int c = 5; c >= 0; c--) begin
            push(1'b1, 5, c, 1'b0);
            flick_on_last();
        end
        push(1'b0, 0, 0, 1'b1);
        flick_on_last();
        phases(0, 5);
        finish_seq();
        run("t5");

        start();
        phases(0, 1);
        ramp(2, 6, 9);
        run("t6");
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async", {11'd0, led, busy, step_o, done}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t6_hold%0d", i),
                {11'd0, led, busy, step_o, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 0, 0, 1'b0);
        push(1'b0, 0, 0, 1'b0);
        run("t6_post");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
